rsv_muldiv_issue: RTL
=====================

Name: rsv_muldiv_issue

Overview:
- Reservation station for the multiply/divide execution unit.
- Accepts renamed uops from dispatch and holds them until both sources are ready.
- Captures operand data from the writeback wakeup bus.
- Issues the oldest ready entry to the muldiv unit when that unit is idle.
- Handles CSR-trap, branch-mispredict and load/store-order flushes by ROB age.

Parameters:
DEPTH, 4, number of queue entries (power of 2, 2..8)
PRF_CODE_W, 7, physical register tag width
PRF_DATA_W, 32, operand data width
DECINFO_W, 16, decode-info bus width
EXCP_W, 5, exception code width
ROB_ID_W, 8, ROB id width (MSB is the wrap bit)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
i_disp_vld  in  1  dispatch request
o_disp_rdy  out  1  free entry available (high when count<DEPTH)
i_disp_src1_vld, i_disp_src2_vld  in  1 each  source used
i_disp_src1_rdy, i_disp_src2_rdy  in  1 each  source data already valid at dispatch
i_disp_src1_code, i_disp_src2_code  in  PRF_CODE_W each  source tags
i_disp_src1_dat, i_disp_src2_dat  in  PRF_DATA_W each  source data (meaningful when rdy)
i_disp_dst_vld / i_disp_dst_code  in  1 / PRF_CODE_W  destination
i_disp_decinfo  in  DECINFO_W  uop info
i_disp_excp_code  in  EXCP_W  exception code
i_disp_rob_id  in  ROB_ID_W  ROB id
i_wb_vld / i_wb_code / i_wb_dat  in  1 / PRF_CODE_W / PRF_DATA_W  wakeup/writeback bus
i_exu_rdy  in  1  muldiv unit idle, may accept
o_rsv_exu_vld  out  1  issue strobe
o_rsv_exu_src1_vld/dat, o_rsv_exu_src2_vld/dat, o_rsv_exu_dst_vld/code, o_rsv_exu_decinfo_bus, o_rsv_exu_excp_code, o_rsv_exu_rob_id  out  matching widths  issued uop fields
i_csr_trap_flush  in  1  kill all
i_exu_mis_flush / i_exu_mis_rob_id  in  1 / ROB_ID_W  mispredict flush
i_exu_ls_flush / i_exu_ls_rob_id  in  1 / ROB_ID_W  load/store flush

Behaviour:
- Reset:
  - All entry valid bits clear.
  - o_rsv_exu_vld=0, o_disp_rdy=1.
  - All o_rsv_exu data outputs 0.
- Age test older(a,b):
  - MSBs differ: a[6:0] >= b[6:0].
  - MSBs equal: a[6:0] < b[6:0].
- Flush id:
  - Both mis and ls flush active: use the older of the two ids.
  - Otherwise use whichever flush is active.
  - An entry or dispatch is killed when older(flush_id, its rob_id) holds.
  - The flushing uop itself is kept.
- Trap flush:
  - Clears every entry next edge.
  - Blocks dispatch and issue in that cycle.
- Dispatch:
  - Accepted when i_disp_vld & o_disp_rdy, and the uop is not killed by a same-cycle flush.
  - Written into the lowest free entry.
  - An unused source (vld=0) is marked ready.
- Wakeup:
  - Each cycle, every valid not-ready source whose tag equals i_wb_code (with i_wb_vld) latches i_wb_dat and becomes ready next edge.
  - A same-cycle wakeup also applies to the uop being dispatched.
- Select and issue:
  - Ready entry = valid, both sources ready, not killed this cycle.
  - Select the oldest ready entry by the age test.
  - o_rsv_exu_vld = any ready & i_exu_rdy & ~i_csr_trap_flush.
  - Outputs are driven combinationally from the selected entry's registers.
  - The issued entry frees on the next edge.
  - At most one issue per cycle.
- Latency:
  - Dispatch with both sources ready at cycle N: earliest issue at N+1.
  - Wakeup at cycle N: earliest issue at N+1.
  - Wakeup does not bypass into same-cycle select.
- Full:
  - o_disp_rdy=0 when DEPTH entries are valid.
  - An entry freed by issue or flush in cycle N is visible as free from N+1; no same-cycle reuse.
- Exceptions:
  - Entries with nonzero excp_code are issued like any other uop, once their sources are ready.
- Reset mid-operation asynchronously clears all state.

Test Plan:
1. Dispatch uop rob_id=0x05, both srcs rdy (src1=7, src2=6), i_exu_rdy=1 -> o_rsv_exu_vld next cycle with dat 7/6, rob_id 0x05; queue then empty.
2. Dispatch rob_id=0x03, src2 tag 0x12 not ready -> no issue. Drive i_wb_vld, code 0x12, dat 0xDEADBEEF -> issue the following cycle with src2_dat=0xDEADBEEF.
3. Fill 4 ready entries with i_exu_rdy=0 -> o_disp_rdy=0, 5th dispatch ignored. Raise i_exu_rdy -> issue in age order, including across the wrap (0x7E, 0x7F, 0x80, 0x81).
4. Entries 0x10, 0x12, 0x14; i_exu_mis_flush id 0x11 plus i_exu_ls_flush id 0x13 -> 0x12 and 0x14 removed, 0x10 remains and issues.
5. i_csr_trap_flush concurrent with dispatch and a pending ready issue -> no o_rsv_exu_vld, dispatch dropped, queue empty next cycle, o_disp_rdy=1.
6. Assert rst while 3 entries are valid -> o_rsv_exu_vld=0 immediately; after release, no stale issue.

Source files
------------

// File: rtl/rsv_muldiv_issue_if.sv
// ---------------------------------------------------------------------------
// rsv_muldiv_issue_if
// Bundle of every non-clock signal of the muldiv reservation station.
//   dispatch : i_disp_* in, o_disp_rdy out
//   wakeup   : i_wb_vld / i_wb_code / i_wb_dat
//   issue    : i_exu_rdy in, o_rsv_exu_* out
//   flushes  : i_csr_trap_flush, i_exu_mis_*, i_exu_ls_*
// slave  = the reservation station, master = whoever drives it.
// ---------------------------------------------------------------------------
interface rsv_muldiv_issue_if #(
  parameter int PRF_CODE_W = 7,
  parameter int PRF_DATA_W = 32,
  parameter int DECINFO_W  = 16,
  parameter int EXCP_W     = 5,
  parameter int ROB_ID_W   = 8
);
  logic                  i_disp_vld;
  logic                  o_disp_rdy;
  logic                  i_disp_src1_vld, i_disp_src2_vld;
  logic                  i_disp_src1_rdy, i_disp_src2_rdy;
  logic [PRF_CODE_W-1:0] i_disp_src1_code, i_disp_src2_code;
  logic [PRF_DATA_W-1:0] i_disp_src1_dat, i_disp_src2_dat;
  logic                  i_disp_dst_vld;
  logic [PRF_CODE_W-1:0] i_disp_dst_code;
  logic [DECINFO_W-1:0]  i_disp_decinfo;
  logic [EXCP_W-1:0]     i_disp_excp_code;
  logic [ROB_ID_W-1:0]   i_disp_rob_id;
  logic                  i_wb_vld;
  logic [PRF_CODE_W-1:0] i_wb_code;
  logic [PRF_DATA_W-1:0] i_wb_dat;
  logic                  i_exu_rdy;
  logic                  o_rsv_exu_vld;
  logic                  o_rsv_exu_src1_vld, o_rsv_exu_src2_vld;
  logic [PRF_DATA_W-1:0] o_rsv_exu_src1_dat, o_rsv_exu_src2_dat;
  logic                  o_rsv_exu_dst_vld;
  logic [PRF_CODE_W-1:0] o_rsv_exu_dst_code;
  logic [DECINFO_W-1:0]  o_rsv_exu_decinfo_bus;
  logic [EXCP_W-1:0]     o_rsv_exu_excp_code;
  logic [ROB_ID_W-1:0]   o_rsv_exu_rob_id;
  logic                  i_csr_trap_flush;
  logic                  i_exu_mis_flush;
  logic [ROB_ID_W-1:0]   i_exu_mis_rob_id;
  logic                  i_exu_ls_flush;
  logic [ROB_ID_W-1:0]   i_exu_ls_rob_id;

  modport slave (
    input  i_disp_vld, i_disp_src1_vld, i_disp_src2_vld, i_disp_src1_rdy, i_disp_src2_rdy,
           i_disp_src1_code, i_disp_src2_code, i_disp_src1_dat, i_disp_src2_dat,
           i_disp_dst_vld, i_disp_dst_code, i_disp_decinfo, i_disp_excp_code, i_disp_rob_id,
           i_wb_vld, i_wb_code, i_wb_dat, i_exu_rdy,
           i_csr_trap_flush, i_exu_mis_flush, i_exu_mis_rob_id, i_exu_ls_flush, i_exu_ls_rob_id,
    output o_disp_rdy, o_rsv_exu_vld, o_rsv_exu_src1_vld, o_rsv_exu_src2_vld,
           o_rsv_exu_src1_dat, o_rsv_exu_src2_dat, o_rsv_exu_dst_vld, o_rsv_exu_dst_code,
           o_rsv_exu_decinfo_bus, o_rsv_exu_excp_code, o_rsv_exu_rob_id
  );

  modport master (
    output i_disp_vld, i_disp_src1_vld, i_disp_src2_vld, i_disp_src1_rdy, i_disp_src2_rdy,
           i_disp_src1_code, i_disp_src2_code, i_disp_src1_dat, i_disp_src2_dat,
           i_disp_dst_vld, i_disp_dst_code, i_disp_decinfo, i_disp_excp_code, i_disp_rob_id,
           i_wb_vld, i_wb_code, i_wb_dat, i_exu_rdy,
           i_csr_trap_flush, i_exu_mis_flush, i_exu_mis_rob_id, i_exu_ls_flush, i_exu_ls_rob_id,
    input  o_disp_rdy, o_rsv_exu_vld, o_rsv_exu_src1_vld, o_rsv_exu_src2_vld,
           o_rsv_exu_src1_dat, o_rsv_exu_src2_dat, o_rsv_exu_dst_vld, o_rsv_exu_dst_code,
           o_rsv_exu_decinfo_bus, o_rsv_exu_excp_code, o_rsv_exu_rob_id
  );
endinterface

// File: rtl/rsv_muldiv_issue.sv
// ---------------------------------------------------------------------------
// rsv_muldiv_issue
// Reservation station in front of the multiply/divide unit. Holds up to DEPTH
// renamed uops, captures source operands from the wakeup bus, and issues the
// oldest fully-ready uop whenever the unit is idle. Flushes remove entries
// younger than the flushing ROB id; a CSR trap clears everything.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - rsv_muldiv_issue_if.slave (dispatch, wakeup, issue, flush signals)
// ---------------------------------------------------------------------------
module rsv_muldiv_issue #(
  parameter int DEPTH      = 4,
  parameter int PRF_CODE_W = 7,
  parameter int PRF_DATA_W = 32,
  parameter int DECINFO_W  = 16,
  parameter int EXCP_W     = 5,
  parameter int ROB_ID_W   = 8
) (
  input logic            clk,
  input logic            rst,
  rsv_muldiv_issue_if.slave bus
);

  typedef struct packed {
    logic                  vld;
    logic                  s1_vld;
    logic                  s1_rdy;
    logic [PRF_CODE_W-1:0] s1_code;
    logic [PRF_DATA_W-1:0] s1_dat;
    logic                  s2_vld;
    logic                  s2_rdy;
    logic [PRF_CODE_W-1:0] s2_code;
    logic [PRF_DATA_W-1:0] s2_dat;
    logic                  dst_vld;
    logic [PRF_CODE_W-1:0] dst_code;
    logic [DECINFO_W-1:0]  decinfo;
    logic [EXCP_W-1:0]     excp;
    logic [ROB_ID_W-1:0]   rob_id;
  } entry_t;

  // a is older than b; the MSB is a wrap bit, so a differing MSB flips the sense
  function automatic logic older(input logic [ROB_ID_W-1:0] a, input logic [ROB_ID_W-1:0] b);
    if (a[ROB_ID_W-1] != b[ROB_ID_W-1])
      return a[ROB_ID_W-2:0] >= b[ROB_ID_W-2:0];
    return a[ROB_ID_W-2:0] < b[ROB_ID_W-2:0];
  endfunction

  entry_t              ent [DEPTH];
  logic [DEPTH-1:0]    vld_vec, kill_vec, rdy_vec, sel_oh, free_oh, issue_oh;
  entry_t              sel_ent, out_ent, disp_ent;
  logic                flush_any, trap, issue, disp_rdy, disp_kill, disp_acc;
  logic [ROB_ID_W-1:0] flush_id;

  assign trap      = bus.i_csr_trap_flush;
  assign flush_any = bus.i_exu_mis_flush | bus.i_exu_ls_flush;

  // With both flushes active the older id wins, since it kills a superset.
  always_comb begin
    flush_id = bus.i_exu_ls_rob_id;
    if (bus.i_exu_mis_flush && bus.i_exu_ls_flush) begin
      if (older(bus.i_exu_mis_rob_id, bus.i_exu_ls_rob_id))
        flush_id = bus.i_exu_mis_rob_id;
    end else if (bus.i_exu_mis_flush) begin
      flush_id = bus.i_exu_mis_rob_id;
    end
  end

  assign disp_rdy  = ~&vld_vec;
  assign disp_kill = flush_any & older(flush_id, bus.i_disp_rob_id);
  assign disp_acc  = bus.i_disp_vld & disp_rdy & ~trap & ~disp_kill;

  // Incoming uop, with unused sources forced ready and same-cycle wakeup merged.
  always_comb begin
    disp_ent          = '0;
    disp_ent.vld      = 1'b1;
    disp_ent.s1_vld   = bus.i_disp_src1_vld;
    disp_ent.s1_code  = bus.i_disp_src1_code;
    disp_ent.s1_dat   = bus.i_disp_src1_dat;
    disp_ent.s1_rdy   = ~bus.i_disp_src1_vld | bus.i_disp_src1_rdy;
    disp_ent.s2_vld   = bus.i_disp_src2_vld;
    disp_ent.s2_code  = bus.i_disp_src2_code;
    disp_ent.s2_dat   = bus.i_disp_src2_dat;
    disp_ent.s2_rdy   = ~bus.i_disp_src2_vld | bus.i_disp_src2_rdy;
    disp_ent.dst_vld  = bus.i_disp_dst_vld;
    disp_ent.dst_code = bus.i_disp_dst_code;
    disp_ent.decinfo  = bus.i_disp_decinfo;
    disp_ent.excp     = bus.i_disp_excp_code;
    disp_ent.rob_id   = bus.i_disp_rob_id;
    if (bus.i_wb_vld && !disp_ent.s1_rdy && bus.i_wb_code == bus.i_disp_src1_code) begin
      disp_ent.s1_rdy = 1'b1;
      disp_ent.s1_dat = bus.i_wb_dat;
    end
    if (bus.i_wb_vld && !disp_ent.s2_rdy && bus.i_wb_code == bus.i_disp_src2_code) begin
      disp_ent.s2_rdy = 1'b1;
      disp_ent.s2_dat = bus.i_wb_dat;
    end
  end

  // Oldest ready entry; equal ages cannot occur, ties keep the lower slot.
  always_comb begin
    logic found;
    found   = 1'b0;
    sel_oh  = '0;
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_vec[i] && (!found || older(ent[i].rob_id, sel_ent.rob_id))) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_ent   = ent[i];
        found     = 1'b1;
      end
    end
  end

  // Lowest free slot, judged on registered valids only (no same-cycle reuse).
  always_comb begin
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld_vec[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign issue    = (|rdy_vec) & bus.i_exu_rdy & ~trap;
  assign issue_oh = sel_oh & {DEPTH{issue}};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      entry_t ent_q, ent_d;

      assign ent[gi]      = ent_q;
      assign vld_vec[gi]  = ent_q.vld;
      assign kill_vec[gi] = ent_q.vld & flush_any & older(flush_id, ent_q.rob_id);
      assign rdy_vec[gi]  = ent_q.vld & ent_q.s1_rdy & ent_q.s2_rdy & ~kill_vec[gi];

      always_comb begin
        ent_d = ent_q;
        if (bus.i_wb_vld && ent_q.vld) begin
          if (!ent_q.s1_rdy && ent_q.s1_code == bus.i_wb_code) begin
            ent_d.s1_rdy = 1'b1;
            ent_d.s1_dat = bus.i_wb_dat;
          end
          if (!ent_q.s2_rdy && ent_q.s2_code == bus.i_wb_code) begin
            ent_d.s2_rdy = 1'b1;
            ent_d.s2_dat = bus.i_wb_dat;
          end
        end
        if (issue_oh[gi] || kill_vec[gi] || trap)
          ent_d.vld = 1'b0;
        // free_oh only points at an invalid slot, so this never hits a live entry
        if (disp_acc && free_oh[gi])
          ent_d = disp_ent;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ent_q <= '0;
        else     ent_q <= ent_d;
      end
    end
  endgenerate

  // Data outputs are held at zero whenever nothing issues.
  assign out_ent = issue ? sel_ent : '0;

  assign bus.o_disp_rdy            = disp_rdy;
  assign bus.o_rsv_exu_vld         = issue;
  assign bus.o_rsv_exu_src1_vld    = out_ent.s1_vld;
  assign bus.o_rsv_exu_src1_dat    = out_ent.s1_dat;
  assign bus.o_rsv_exu_src2_vld    = out_ent.s2_vld;
  assign bus.o_rsv_exu_src2_dat    = out_ent.s2_dat;
  assign bus.o_rsv_exu_dst_vld     = out_ent.dst_vld;
  assign bus.o_rsv_exu_dst_code    = out_ent.dst_code;
  assign bus.o_rsv_exu_decinfo_bus = out_ent.decinfo;
  assign bus.o_rsv_exu_excp_code   = out_ent.excp;
  assign bus.o_rsv_exu_rob_id      = out_ent.rob_id;

endmodule
